// File: rtl/bist_response_capture.sv
// Exhaustive pattern generator plus MISR response compactor for small benchmark DUTs.
// Patterns run 0..2^N_IN-1; responses are realigned by DUT_LAT and folded into a signature.
module bist_response_capture #(
  parameter int               N_IN    = 6,
  parameter int               SIG_W   = 16,
  parameter logic [SIG_W-1:0] POLY    = 16'h1021,
  parameter logic [SIG_W-1:0] SEED    = '0,
  parameter logic [SIG_W-1:0] GOLDEN  = 16'h0000,
  parameter int               DUT_LAT = 0
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  output logic [N_IN-1:0]  pattern_out,
  output logic             pattern_valid,
  input  logic             resp_in,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic             pass,
  output logic [N_IN:0]    vec_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t         state, state_nxt;
  logic [2:0]     drain_cnt;
  logic           sample_en;
  logic           last_pat;
  logic [SIG_W-1:0] sig_shift, sig_nxt;

  assign last_pat = (pattern_out == {N_IN{1'b1}});

  // Valid delay line: response of a pattern arrives DUT_LAT cycles after it is presented.
  generate
    if (DUT_LAT == 0) begin : g_nolat
      assign sample_en = pattern_valid;
    end else begin : g_lat
      logic [DUT_LAT-1:0] vld_pipe;
      always_ff @(posedge CK or posedge reset) begin
        if (reset) vld_pipe <= '0;
        else       vld_pipe <= (vld_pipe << 1) | DUT_LAT'(pattern_valid);
      end
      assign sample_en = vld_pipe[DUT_LAT-1];
    end
  endgenerate

  always_comb begin
    sig_shift = {signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? POLY : '0)
              ^ {{(SIG_W-1){1'b0}}, resp_in};
    sig_nxt   = sample_en ? sig_shift : signature;
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_pat) state_nxt = (DUT_LAT > 0) ? DRAIN : DONE;
      DRAIN:   if (drain_cnt == 3'(DUT_LAT-1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == DRAIN);
    done = (state == DONE);
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      pattern_out   <= '0;
      pattern_valid <= 1'b0;
      signature     <= SEED;
      pass          <= 1'b0;
      vec_count     <= '0;
      drain_cnt     <= '0;
    end else if (state == IDLE && start) begin
      signature     <= SEED;
      vec_count     <= '0;
      pass          <= 1'b0;
      pattern_out   <= '0;
      pattern_valid <= 1'b1;
      drain_cnt     <= '0;
    end else begin
      if (sample_en) begin
        signature <= sig_shift;
        vec_count <= vec_count + (N_IN+1)'(1);
      end
      if (state == RUN) begin
        if (last_pat) pattern_valid <= 1'b0;
        else          pattern_out   <= pattern_out + N_IN'(1);
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
      // Final sample lands on the edge entering DONE, so compare the post-sample value.
      if (state_nxt == DONE && state != DONE) pass <= (sig_nxt == GOLDEN);
    end
  end

endmodule

// File: tb/tb_bist_response_capture.sv
// Directed bench: a zero-latency instance driven from a vector table, and a DUT_LAT=2
// instance fed by a two-stage delayed response model.
module tb_bist_response_capture;

  logic        CK, reset;
  logic        start0, resp0, pv0, busy0, done0, pass0;
  logic [5:0]  po0;
  logic [15:0] sig0;
  logic [6:0]  vc0;
  logic        start1, resp1, pv1, busy1, done1, pass1;
  logic [5:0]  po1;
  logic [15:0] sig1;
  logic [6:0]  vc1;
  logic [63:0] mask;
  logic        d1, d2;

  int nvec = 0;
  int nmis = 0;

  bist_response_capture u_dut0 (
    .CK(CK), .reset(reset), .start(start0), .pattern_out(po0), .pattern_valid(pv0),
    .resp_in(resp0), .busy(busy0), .done(done0), .signature(sig0), .pass(pass0),
    .vec_count(vc0));

  bist_response_capture #(.DUT_LAT(2)) u_dut1 (
    .CK(CK), .reset(reset), .start(start1), .pattern_out(po1), .pattern_valid(pv1),
    .resp_in(resp1), .busy(busy1), .done(done1), .signature(sig1), .pass(pass1),
    .vec_count(vc1));

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  assign resp0 = pv0 & mask[po0];

  // Two-stage pipelined DUT: output is (pattern==47) two cycles after presentation.
  always @(posedge CK or posedge reset) begin
    if (reset) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d1 <= pv1 && (po1 == 6'd47);
      d2 <= d1;
    end
  end
  assign resp1 = d2;

  typedef struct {
    string       name;
    logic [63:0] mask;
    logic [15:0] sig;
    logic        pas;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_pat"},   32'(po0),   0);
    check({nm, "_pv"},    32'(pv0),   0);
    check({nm, "_busy"},  32'(busy0), 0);
    check({nm, "_done"},  32'(done0), 0);
    check({nm, "_sig"},   32'(sig0),  0);
    check({nm, "_pass"},  32'(pass0), 0);
    check({nm, "_vc"},    32'(vc0),   0);
  endtask

  // One full run on instance 0; post>0 adds a hold/no-second-done window after done.
  task automatic run0(input string nm, input logic [63:0] m, input bit repulse,
                      input logic [15:0] es, input logic ep, input int post);
    int cyc, nvalid, ndone;
    bit seq_ok;
    mask = m;
    @(negedge CK) start0 = 1'b1;
    cyc = 0; nvalid = 0; seq_ok = 1'b1;
    while (!done0 && cyc < 200) begin
      @(negedge CK);
      cyc++;
      start0 = repulse && (cyc == 10 || cyc == 65);
      if (cyc == 1) begin
        check({nm, "_first_pat"}, 32'(po0),   0);
        check({nm, "_vc_clear"},  32'(vc0),   0);
        check({nm, "_reseed"},    32'(sig0),  0);
        check({nm, "_pass_clr"},  32'(pass0), 0);
        check({nm, "_busy"},      32'(busy0), 1);
      end
      if (pv0) begin
        if (po0 != 6'(nvalid)) seq_ok = 1'b0;
        nvalid++;
      end
    end
    check({nm, "_latency"}, 32'(cyc),    65);
    check({nm, "_nvalid"},  32'(nvalid), 64);
    check({nm, "_seq"},     32'(seq_ok), 1);
    check({nm, "_sig"},     32'(sig0),   32'(es));
    check({nm, "_pass"},    32'(pass0),  32'(ep));
    check({nm, "_vc"},      32'(vc0),    64);
    check({nm, "_busy_dn"}, 32'(busy0),  0);
    check({nm, "_pat_hold"},32'(po0),    63);
    if (post > 0) begin
      ndone = 0;
      for (int i = 0; i < post; i++) begin
        @(negedge CK);
        start0 = 1'b0;
        if (done0) ndone++;
      end
      check({nm, "_one_done"},  32'(ndone), 0);
      check({nm, "_sig_hold"},  32'(sig0),  32'(es));
      check({nm, "_pass_hold"}, 32'(pass0), 32'(ep));
      check({nm, "_vc_hold"},   32'(vc0),   64);
    end
  endtask

  initial begin
    int cyc, nv, ndone;
    tbl[0] = '{"none",     64'h0,                      16'h0000, 1'b1};
    tbl[1] = '{"hot63",    64'h8000_0000_0000_0000,    16'h0001, 1'b0};
    tbl[2] = '{"hot62",    64'h4000_0000_0000_0000,    16'h0002, 1'b0};
    tbl[3] = '{"hot48",    64'h0001_0000_0000_0000,    16'h8000, 1'b0};
    tbl[4] = '{"hot47",    64'h0000_8000_0000_0000,    16'h1021, 1'b0};
    tbl[5] = '{"hot63_62", 64'hC000_0000_0000_0000,    16'h0003, 1'b0};
    tbl[6] = '{"hot48_47", 64'h0001_8000_0000_0000,    16'h9021, 1'b0};

    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; mask = '0;
    #12;
    check_reset_vals("por");
    @(negedge CK) reset = 1'b0;

    foreach (tbl[i]) run0(tbl[i].name, tbl[i].mask, 1'b0, tbl[i].sig, tbl[i].pas, 5);

    run0("repulse", tbl[4].mask, 1'b1, 16'h1021, 1'b0, 5);

    // Asynchronous reset mid-run, with a non-zero signature already accumulated.
    mask = 64'h20;
    @(negedge CK) start0 = 1'b1;
    @(negedge CK) start0 = 1'b0;
    repeat (29) @(negedge CK);
    check("mid_busy", 32'(busy0), 1);
    check("mid_sig_nz", 32'(sig0 != 16'h0), 1);
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge CK) reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge CK);
      if (done0) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 0);
    run0("after_rst", 64'h0, 1'b0, 16'h0000, 1'b1, 5);

    // Back-to-back: second start issued in the cycle right after done.
    run0("b2b_a", tbl[1].mask, 1'b0, 16'h0001, 1'b0, 0);
    run0("b2b_b", 64'h0, 1'b0, 16'h0000, 1'b1, 5);

    // Latency-2 instance.
    @(negedge CK) start1 = 1'b1;
    @(negedge CK) start1 = 1'b0;
    cyc = 1; nv = 0;
    while (!done1 && cyc < 200) begin
      if (pv1) nv++;
      @(negedge CK);
      cyc++;
    end
    check("lat2_latency", 32'(cyc),   67);
    check("lat2_nvalid",  32'(nv),    64);
    check("lat2_sig",     32'(sig1),  32'h1021);
    check("lat2_pass",    32'(pass1), 0);
    check("lat2_vc",      32'(vc1),   64);
    check("lat2_busy",    32'(busy1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
